// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for a 5-stage RV32IM pipeline. Merges
//               decode hazards, fetch redirects, execute mispredicts, divider
//               and data-memory waits and EBREAK halt into per-stage
//               stall/flush enables, a divider start pulse and two
//               saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                D_dataHazard_i,
  input  logic                D_predictPC_i,
  input  logic                E_correctPC_i,
  input  logic                E_isDIV_i,
  input  logic                E_divDone_i,
  input  logic                E_isEBREAK_i,
  input  logic                M_memBusy_i,
  input  logic                resume_i,
  output logic                F_stall_o,
  output logic                D_stall_o,
  output logic                D_flush_o,
  output logic                E_stall_o,
  output logic                E_flush_o,
  output logic                M_stall_o,
  output logic                E_divStart_o,
  output logic                halted_o,
  output logic [1:0]          state_o,
  output logic [CNT_BITS-1:0] stallCycles_o,
  output logic [CNT_BITS-1:0] flushCount_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DIV_WAIT = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT     = 2'd3;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_BITS-1:0] flush_cnt_q, flush_cnt_d;
  logic                correct_accept;

  // State register; reset returns to RUN from any wait state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Next state: a memory wait overrides everything, but DIV_WAIT and HALT
  // keep their identity across it so the pending divide/halt is not lost.
  // MEM_WAIT without busy behaves exactly like RUN.
  always_comb begin
    state_d = state_q;
    if (M_memBusy_i) begin
      if (state_q == ST_RUN || state_q == ST_MEM_WAIT) state_d = ST_MEM_WAIT;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (E_isDIV_i)         state_d = ST_DIV_WAIT;
          else if (E_isEBREAK_i) state_d = ST_HALT;
          else                   state_d = ST_RUN;
        end
        ST_DIV_WAIT: if (E_divDone_i) state_d = ST_RUN;
        ST_HALT:     if (resume_i)    state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  // Mealy outputs in priority order: reset, memBusy, div, halt, correctPC,
  // dataHazard, predictPC
  always_comb begin
    F_stall_o      = 1'b0;
    D_stall_o      = 1'b0;
    E_stall_o      = 1'b0;
    M_stall_o      = 1'b0;
    D_flush_o      = 1'b0;
    E_flush_o      = 1'b0;
    E_divStart_o   = 1'b0;
    correct_accept = 1'b0;
    if (reset_i) begin
      D_flush_o = 1'b1;
      E_flush_o = 1'b1;
    end else if (M_memBusy_i) begin
      F_stall_o = 1'b1;
      D_stall_o = 1'b1;
      E_stall_o = 1'b1;
      M_stall_o = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (E_isDIV_i) begin
            E_divStart_o = 1'b1;
            F_stall_o    = 1'b1;
            D_stall_o    = 1'b1;
            E_stall_o    = 1'b1;
          end else if (E_isEBREAK_i) begin
            // EBREAK advances this cycle; the halt takes effect next cycle
          end else if (E_correctPC_i) begin
            D_flush_o      = 1'b1;
            E_flush_o      = 1'b1;
            correct_accept = 1'b1;
          end else if (D_dataHazard_i) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_flush_o = 1'b1;
          end else if (D_predictPC_i) begin
            D_flush_o = 1'b1;
          end
        end
        ST_DIV_WAIT: begin
          if (!E_divDone_i) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_stall_o = 1'b1;
          end
        end
        default: begin
          F_stall_o = 1'b1;
          D_stall_o = 1'b1;
          E_stall_o = 1'b1;
        end
      endcase
    end
  end

  // Saturating counter next values; halted cycles are not stall cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (F_stall_o && state_q != ST_HALT && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (correct_accept && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Performance counter registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted_o      = (state_q == ST_HALT);
  assign state_o       = state_q;
  assign stallCycles_o = stall_cnt_q;
  assign flushCount_o  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Two instances (32-bit
//               and 4-bit counters) share stimulus; a behavioural model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic D_dataHazard_i = 1'b0, D_predictPC_i = 1'b0, E_correctPC_i = 1'b0;
  logic E_isDIV_i = 1'b0, E_divDone_i = 1'b0, E_isEBREAK_i = 1'b0;
  logic M_memBusy_i = 1'b0, resume_i = 1'b0;

  logic        F_stall_o, D_stall_o, D_flush_o, E_stall_o, E_flush_o, M_stall_o;
  logic        E_divStart_o, halted_o;
  logic [1:0]  state_o;
  logic [31:0] stallCycles_o, flushCount_o;

  logic        F_stall4, D_stall4, D_flush4, E_stall4, E_flush4, M_stall4;
  logic        divStart4, halted4;
  logic [1:0]  state4;
  logic [3:0]  stallCycles4, flushCount4;

  int errors = 0;
  int checks = 0;

  // reference model state
  int     m_state = 0;   // 0 RUN, 1 DIV_WAIT, 2 MEM_WAIT, 3 HALT
  longint m_stalls = 0;
  longint m_flushes = 0;
  int     starts_seen = 0;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(.CNT_BITS(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .D_dataHazard_i(D_dataHazard_i), .D_predictPC_i(D_predictPC_i),
    .E_correctPC_i(E_correctPC_i), .E_isDIV_i(E_isDIV_i),
    .E_divDone_i(E_divDone_i), .E_isEBREAK_i(E_isEBREAK_i),
    .M_memBusy_i(M_memBusy_i), .resume_i(resume_i),
    .F_stall_o(F_stall_o), .D_stall_o(D_stall_o), .D_flush_o(D_flush_o),
    .E_stall_o(E_stall_o), .E_flush_o(E_flush_o), .M_stall_o(M_stall_o),
    .E_divStart_o(E_divStart_o), .halted_o(halted_o), .state_o(state_o),
    .stallCycles_o(stallCycles_o), .flushCount_o(flushCount_o)
  );

  pipeline_ctrl #(.CNT_BITS(4)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i),
    .D_dataHazard_i(D_dataHazard_i), .D_predictPC_i(D_predictPC_i),
    .E_correctPC_i(E_correctPC_i), .E_isDIV_i(E_isDIV_i),
    .E_divDone_i(E_divDone_i), .E_isEBREAK_i(E_isEBREAK_i),
    .M_memBusy_i(M_memBusy_i), .resume_i(resume_i),
    .F_stall_o(F_stall4), .D_stall_o(D_stall4), .D_flush_o(D_flush4),
    .E_stall_o(E_stall4), .E_flush_o(E_flush4), .M_stall_o(M_stall4),
    .E_divStart_o(divStart4), .halted_o(halted4), .state_o(state4),
    .stallCycles_o(stallCycles4), .flushCount_o(flushCount4)
  );

  function automatic longint sat(longint v, int bits);
    longint mx;
    mx = (longint'(1) << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already applied; check Mealy outputs mid-cycle,
  // then advance the model across the rising edge.
  task automatic step();
    int  depth;     // how many stages from fetch are held: 0, 2 (F,D), 3 (F,D,E), 4 (all)
    bit  dfl, efl, dstart, take;
    int  nxt;
    logic [7:0] exp_flags;
    #3;
    if (reset_i) begin
      m_state = 0; m_stalls = 0; m_flushes = 0;
    end
    depth = 0; dfl = 0; efl = 0; dstart = 0; take = 0; nxt = m_state;
    if (reset_i) begin
      dfl = 1; efl = 1; nxt = 0;
    end else if (M_memBusy_i) begin
      depth = 4;
      nxt = (m_state == 1 || m_state == 3) ? m_state : 2;
    end else if (m_state == 1) begin
      depth = E_divDone_i ? 0 : 3;
      nxt   = E_divDone_i ? 0 : 1;
    end else if (m_state == 3) begin
      depth = 3;
      nxt   = resume_i ? 0 : 3;
    end else begin
      nxt = 0;
      if (E_isDIV_i)              begin dstart = 1; depth = 3; nxt = 1; end
      else if (E_isEBREAK_i)      nxt = 3;
      else if (E_correctPC_i)     begin dfl = 1; efl = 1; take = 1; end
      else if (D_dataHazard_i)    begin depth = 2; efl = 1; end
      else if (D_predictPC_i)     dfl = 1;
    end
    exp_flags = {depth >= 2, depth >= 2, depth >= 3, depth >= 4,
                 dfl, efl, dstart, m_state == 3};
    chk("flags", {F_stall_o, D_stall_o, E_stall_o, M_stall_o,
                  D_flush_o, E_flush_o, E_divStart_o, halted_o}, exp_flags);
    chk("flags4", {F_stall4, D_stall4, E_stall4, M_stall4,
                   D_flush4, E_flush4, divStart4, halted4}, exp_flags);
    chk("state", state_o, m_state);
    chk("state4", state4, m_state);
    chk("stallCycles", stallCycles_o, sat(m_stalls, 32));
    chk("flushCount", flushCount_o, sat(m_flushes, 32));
    chk("stallCycles4", stallCycles4, sat(m_stalls, 4));
    chk("flushCount4", flushCount4, sat(m_flushes, 4));
    if (E_divStart_o) starts_seen++;
    @(posedge clk_i);
    if (!reset_i) begin
      if (depth >= 2 && m_state != 3) m_stalls++;
      if (take) m_flushes++;
      m_state = nxt;
    end
    #1;
  endtask

  task automatic idle();
    D_dataHazard_i = 0; D_predictPC_i = 0; E_correctPC_i = 0; E_isDIV_i = 0;
    E_divDone_i = 0; E_isEBREAK_i = 0; M_memBusy_i = 0; resume_i = 0;
  endtask

  longint snap;

  initial begin
    @(posedge clk_i); #1;
    // reset held: bubbles, no stalls, counters zero
    idle(); reset_i = 1;
    step(); step();
    reset_i = 0;
    step();

    // two hazard cycles
    D_dataHazard_i = 1; step(); step();
    idle(); step();
    chk("hazard_stallCycles", stallCycles_o, 2);

    // mispredict with hazard in the same cycle
    E_correctPC_i = 1; D_dataHazard_i = 1; step();
    idle(); step();
    chk("mispredict_flushCount", flushCount_o, 1);

    // divide of 33 wait cycles
    starts_seen = 0;
    E_isDIV_i = 1; step();
    chk("div_enter_state", state_o, 1);
    for (int i = 0; i < 32; i++) step();
    E_divDone_i = 1; step();
    idle(); step();
    chk("div_single_start", starts_seen, 1);

    // memory busy while waiting for the divider
    E_isDIV_i = 1; step(); step(); step();
    M_memBusy_i = 1; step(); step(); step();
    M_memBusy_i = 0; E_divDone_i = 1; step();
    idle(); step();
    chk("div_mem_back_to_run", state_o, 0);

    // EBREAK, ten halted cycles, resume
    E_isEBREAK_i = 1; step();
    idle();
    snap = stallCycles_o;
    for (int i = 0; i < 10; i++) step();
    chk("halt_no_stall_count", stallCycles_o, snap);
    resume_i = 1; step();
    idle(); step();

    // saturation of the 4-bit instance
    D_dataHazard_i = 1;
    for (int i = 0; i < 20; i++) step();
    idle(); step();
    chk("sat4_stallCycles", stallCycles4, 15);

    // reset asserted in the middle of DIV_WAIT
    E_isDIV_i = 1; step(); step();
    #2 reset_i = 1;
    #1;
    chk("rst_mid_div_state", state_o, 0);
    chk("rst_mid_div_cnt", stallCycles_o, 0);
    step();
    reset_i = 0; E_isDIV_i = 0; step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      D_dataHazard_i = ($urandom_range(99) < 25);
      D_predictPC_i  = ($urandom_range(99) < 30);
      E_correctPC_i  = ($urandom_range(99) < 20);
      E_isDIV_i      = ($urandom_range(99) < 10);
      E_divDone_i    = ($urandom_range(99) < 15);
      E_isEBREAK_i   = ($urandom_range(99) < 5);
      M_memBusy_i    = ($urandom_range(99) < 20);
      resume_i       = ($urandom_range(99) < 20);
      reset_i        = ($urandom_range(99) < 2);
      step();
    end
    reset_i = 0; idle(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
